// File: rtl/run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// run_ctrl_pkg
//   Shared types and width helpers for the run controller.
//   - state_e       : controller state (hold, staggered release, run, timeout)
//   - TCNT_W        : width of the saturating expiry counter
//   - seq_width()   : width of the release-sequence counter
//   - wd_width()    : width of the watchdog counter
// -----------------------------------------------------------------------------
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam int unsigned TCNT_W = 8;

  // Must hold every release threshold up to and past the last domain.
  function automatic int unsigned seq_width(input int unsigned rst_cycles,
                                            input int unsigned num_domains,
                                            input int unsigned stagger);
    return $clog2(rst_cycles + num_domains * stagger + 1);
  endfunction

  // Watchdog counts 0 .. MAX_CYCLES-1.
  function automatic int unsigned wd_width(input int unsigned max_cycles);
    return $clog2(max_cycles);
  endfunction

endpackage

// File: rtl/run_ctrl_rst_sync.sv
// -----------------------------------------------------------------------------
// rst_sync
//   Two-flop reset synchroniser: asserts asynchronously, releases on the
//   second rising clock edge after rst_n goes high.
//   Ports:
//     clk          : clock
//     rst_n        : raw asynchronous active-low reset
//     rst_n_sync_o : synchronised active-low reset
// -----------------------------------------------------------------------------
module rst_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_n_sync_o
);

  logic [1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from before the edge and the chain really is two stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_n_sync_o = sync_q[1];

endmodule

// File: rtl/run_ctrl.sv
// -----------------------------------------------------------------------------
// run_ctrl
//   Brings NUM_DOMAINS reset domains out of reset in a staggered order, counts
//   run cycles and supervises the run with a kickable watchdog. On watchdog
//   expiry all domains are put back into reset and either re-sequenced
//   (AUTO_RESTART=1) or held in a terminal TIMEOUT state (AUTO_RESTART=0).
//   Ports:
//     clk           : sole clock
//     rst           : asynchronous active-low reset (sync release internally)
//     kick          : watchdog restart, honoured in RUN only
//     dom_rst       : per-domain active-high reset
//     all_released  : all domains released, state RUN
//     cycle_cnt     : cycles spent in RUN since last (re)sequence, saturating
//     timeout       : sticky, watchdog expired at least once since rst
//     timeout_pulse : one-cycle strobe per expiry
//     timeout_cnt   : number of expiries, saturating at 255
//   All outputs are registered.
// -----------------------------------------------------------------------------
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS  = 4,
  parameter int unsigned RST_CYCLES   = 8,
  parameter int unsigned STAGGER      = 2,
  parameter int unsigned MAX_CYCLES   = 100,
  parameter int unsigned CNT_W        = 32,
  parameter bit          AUTO_RESTART = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   kick,
  output logic [NUM_DOMAINS-1:0] dom_rst,
  output logic                   all_released,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic                   timeout,
  output logic                   timeout_pulse,
  output logic [TCNT_W-1:0]      timeout_cnt
);

  localparam int unsigned SEQ_W = seq_width(RST_CYCLES, NUM_DOMAINS, STAGGER);
  localparam int unsigned WD_W  = wd_width(MAX_CYCLES);

  // Sequence-counter value reached on the edge that releases domain 0 / the
  // last domain (the counter is 0 on edge A0 and +1 every edge after).
  localparam logic [SEQ_W-1:0] SEQ_FIRST = SEQ_W'(RST_CYCLES);
  localparam logic [SEQ_W-1:0] SEQ_LAST  =
    SEQ_W'(RST_CYCLES + (NUM_DOMAINS - 1) * STAGGER);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(MAX_CYCLES - 1);

  logic rst_n_sync;

  state_e                 state_q,         state_d;
  logic [SEQ_W-1:0]       seq_cnt_q,       seq_cnt_d;
  logic [WD_W-1:0]        wd_cnt_q,        wd_cnt_d;
  logic [NUM_DOMAINS-1:0] dom_rst_q,       dom_rst_d;
  logic                   all_released_q,  all_released_d;
  logic [CNT_W-1:0]       cycle_cnt_q,     cycle_cnt_d;
  logic                   timeout_q,       timeout_d;
  logic                   timeout_pulse_q, timeout_pulse_d;
  logic [TCNT_W-1:0]      timeout_cnt_q,   timeout_cnt_d;

  logic [SEQ_W-1:0]       seq_nxt;

  rst_sync u_rst_sync (
    .clk          (clk),
    .rst_n        (rst),
    .rst_n_sync_o (rst_n_sync)
  );

  // Edge A0 is the edge that lifts rst_n_sync; registers below stay in reset
  // through it, so seq_cnt is 0 after A0 and equals k after edge A0+k.
  assign seq_nxt = seq_cnt_q + 1'b1;

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    seq_cnt_d       = seq_cnt_q;
    wd_cnt_d        = wd_cnt_q;
    dom_rst_d       = dom_rst_q;
    all_released_d  = all_released_q;
    cycle_cnt_d     = cycle_cnt_q;
    timeout_d       = timeout_q;
    timeout_pulse_d = 1'b0;
    timeout_cnt_d   = timeout_cnt_q;

    unique case (state_q)
      ST_HOLD, ST_STAGGER: begin
        seq_cnt_d = seq_nxt;
        // A domain drops on the edge the counter reaches its threshold and
        // then stays low because dom_rst_d defaults to the held value.
        for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
          if (seq_nxt >= SEQ_W'(RST_CYCLES + i * STAGGER)) begin
            dom_rst_d[i] = 1'b0;
          end
        end
        // With one domain or zero stagger SEQ_LAST == SEQ_FIRST, so HOLD
        // goes straight to RUN.
        if (seq_nxt >= SEQ_LAST) begin
          state_d        = ST_RUN;
          all_released_d = 1'b1;
          wd_cnt_d       = '0;
          cycle_cnt_d    = '0;
        end else if (seq_nxt >= SEQ_FIRST) begin
          state_d = ST_STAGGER;
        end
      end

      ST_RUN: begin
        if (cycle_cnt_q != '1) begin
          cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
        // Kick has priority over an expiry due on the same edge.
        if (kick) begin
          wd_cnt_d = '0;
        end else if (wd_cnt_q == WD_LAST) begin
          wd_cnt_d        = '0;
          timeout_pulse_d = 1'b1;
          timeout_d       = 1'b1;
          if (timeout_cnt_q != '1) begin
            timeout_cnt_d = timeout_cnt_q + 1'b1;
          end
          dom_rst_d      = '1;
          all_released_d = 1'b0;
          if (AUTO_RESTART) begin
            // This edge acts as a new A0 for the release sequence.
            state_d     = ST_HOLD;
            seq_cnt_d   = '0;
            cycle_cnt_d = '0;
          end else begin
            state_d = ST_TIMEOUT;
          end
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end

      // Terminal until rst: everything holds, kick is ignored.
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q         <= ST_HOLD;
      seq_cnt_q       <= '0;
      wd_cnt_q        <= '0;
      dom_rst_q       <= '1;
      all_released_q  <= 1'b0;
      cycle_cnt_q     <= '0;
      timeout_q       <= 1'b0;
      timeout_pulse_q <= 1'b0;
      timeout_cnt_q   <= '0;
    end else begin
      state_q         <= state_d;
      seq_cnt_q       <= seq_cnt_d;
      wd_cnt_q        <= wd_cnt_d;
      dom_rst_q       <= dom_rst_d;
      all_released_q  <= all_released_d;
      cycle_cnt_q     <= cycle_cnt_d;
      timeout_q       <= timeout_d;
      timeout_pulse_q <= timeout_pulse_d;
      timeout_cnt_q   <= timeout_cnt_d;
    end
  end

  assign dom_rst       = dom_rst_q;
  assign all_released  = all_released_q;
  assign cycle_cnt     = cycle_cnt_q;
  assign timeout       = timeout_q;
  assign timeout_pulse = timeout_pulse_q;
  assign timeout_cnt   = timeout_cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_run_ctrl
//   Directed bench for run_ctrl. Instance dut uses the defaults
//   (4 domains, RST_CYCLES=8, STAGGER=2, MAX_CYCLES=100, auto restart);
//   instance dut_h uses AUTO_RESTART=0, MAX_CYCLES=10 and shares clk/rst.
//   Edge numbering n counts posedges after the RUN-entry edge of dut.
// -----------------------------------------------------------------------------
module tb_run_ctrl;

  logic        clk;
  logic        rst;
  logic        kick;
  logic        kick_h;

  logic [3:0]  dom_rst,       dom_rst_h;
  logic        all_released,  all_released_h;
  logic [31:0] cycle_cnt,     cycle_cnt_h;
  logic        timeout,       timeout_h;
  logic        timeout_pulse, timeout_pulse_h;
  logic [7:0]  timeout_cnt,   timeout_cnt_h;

  int n_checks = 0;
  int n_errors = 0;

  run_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .kick          (kick),
    .dom_rst       (dom_rst),
    .all_released  (all_released),
    .cycle_cnt     (cycle_cnt),
    .timeout       (timeout),
    .timeout_pulse (timeout_pulse),
    .timeout_cnt   (timeout_cnt)
  );

  run_ctrl #(
    .MAX_CYCLES   (10),
    .AUTO_RESTART (1'b0)
  ) dut_h (
    .clk           (clk),
    .rst           (rst),
    .kick          (kick_h),
    .dom_rst       (dom_rst_h),
    .all_released  (all_released_h),
    .cycle_cnt     (cycle_cnt_h),
    .timeout       (timeout_h),
    .timeout_pulse (timeout_pulse_h),
    .timeout_cnt   (timeout_cnt_h)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL tb_time_limit: simulation did not finish, got running required done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string ph);
    check({ph, " dom_rst"},         64'(dom_rst),         64'hf);
    check({ph, " all_released"},    64'(all_released),    64'h0);
    check({ph, " cycle_cnt"},       64'(cycle_cnt),       64'h0);
    check({ph, " timeout"},         64'(timeout),         64'h0);
    check({ph, " timeout_pulse"},   64'(timeout_pulse),   64'h0);
    check({ph, " timeout_cnt"},     64'(timeout_cnt),     64'h0);
    check({ph, " h.dom_rst"},       64'(dom_rst_h),       64'hf);
    check({ph, " h.timeout"},       64'(timeout_h),       64'h0);
  endtask

  // Called at the negedge where rst has just risen. Domain i falls after
  // posedge 10+2i counted from release; all_released after posedge 16.
  task automatic check_sequence(input string ph);
    logic [3:0] e_dom;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) e_dom[i] = (k < 10 + 2 * i);
      check($sformatf("%s dom_rst@%0d", ph, k),      64'(dom_rst),      64'(e_dom));
      check($sformatf("%s all_released@%0d", ph, k), 64'(all_released), 64'(k >= 16));
      check($sformatf("%s cycle_cnt@%0d", ph, k),    64'(cycle_cnt),    64'h0);
      check($sformatf("%s timeout@%0d", ph, k),      64'(timeout),      64'h0);
      check($sformatf("%s h.dom_rst@%0d", ph, k),    64'(dom_rst_h),    64'(e_dom));
    end
  endtask

  initial begin
    logic [3:0]  e_dom;
    logic        e_all, e_to, e_pl;
    logic [31:0] e_cyc;
    logic [7:0]  e_tc;
    int          base, m;

    rst    = 1'b0;
    kick   = 1'b0;
    kick_h = 1'b0;

    // Reset held for 5 cycles, then released at a negedge.
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    check_sequence("seq");

    // Kick schedule for dut: every 50 edges up to 1000, then once at 1100,
    // which is the cycle where wd_cnt sits at 99 (last kick at 1000).
    // Expiries follow at 1200 and, after the re-sequence enters RUN at 1214,
    // at 1314. dut_h expires at 10 and ignores kicks on 11..60.
    for (int n = 1; n <= 1325; n++) begin
      kick   = ((n <= 1000) && (n % 50 == 0)) || (n == 1100);
      kick_h = (n >= 11) && (n <= 60);
      @(posedge clk);
      @(negedge clk);

      if (n < 1200) begin
        e_dom = 4'h0; e_all = 1'b1; e_cyc = 32'(n);
        e_to  = 1'b0; e_pl  = 1'b0; e_tc  = 8'd0;
      end else begin
        base  = (n >= 1314) ? 1314 : 1200;
        m     = n - base;
        for (int i = 0; i < 4; i++) e_dom[i] = (m < 8 + 2 * i);
        e_all = (m >= 14);
        e_cyc = (m >= 14) ? 32'(m - 14) : 32'd0;
        e_to  = 1'b1;
        e_pl  = (m == 0);
        e_tc  = (base == 1314) ? 8'd2 : 8'd1;
      end
      check($sformatf("dom_rst@%0d", n),       64'(dom_rst),       64'(e_dom));
      check($sformatf("all_released@%0d", n),  64'(all_released),  64'(e_all));
      check($sformatf("cycle_cnt@%0d", n),     64'(cycle_cnt),     64'(e_cyc));
      check($sformatf("timeout@%0d", n),       64'(timeout),       64'(e_to));
      check($sformatf("timeout_pulse@%0d", n), 64'(timeout_pulse), 64'(e_pl));
      check($sformatf("timeout_cnt@%0d", n),   64'(timeout_cnt),   64'(e_tc));

      if (n <= 80) begin
        check($sformatf("h.dom_rst@%0d", n),       64'(dom_rst_h),       (n >= 10) ? 64'hf : 64'h0);
        check($sformatf("h.all_released@%0d", n),  64'(all_released_h),  64'(n < 10));
        check($sformatf("h.cycle_cnt@%0d", n),     64'(cycle_cnt_h),     (n >= 10) ? 64'd10 : 64'(n));
        check($sformatf("h.timeout@%0d", n),       64'(timeout_h),       64'(n >= 10));
        check($sformatf("h.timeout_pulse@%0d", n), 64'(timeout_pulse_h), 64'(n == 10));
        check($sformatf("h.timeout_cnt@%0d", n),   64'(timeout_cnt_h),   (n >= 10) ? 64'd1 : 64'd0);
      end
    end
    kick   = 1'b0;
    kick_h = 1'b0;

    // Now mid-STAGGER (dom_rst[1] fell after edge 1324) with timeout set:
    // a one-cycle rst pulse must clear everything without a clock edge.
    rst = 1'b0;
    #1;
    check_reset_values("rst_pulse");
    @(negedge clk);
    rst = 1'b1;
    check_sequence("reseq");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Synthesizable run controller that brings the design's reset domains out of reset and then supervises them. It is the parametrised successor to the bench-level clock/reset/timeout harness.
- Releases N reset domains in a programmable staggered order.
- Counts run cycles.
- Runs a kickable watchdog that, on expiry, either halts or re-sequences all domains.

It sits between the top-level clock/reset pins and every DUT sub-block.

## Interface
Parameters:
- NUM_DOMAINS, 4, number of reset domains (>=1)
- RST_CYCLES, 8, hold cycles before domain 0 is released (>=1)
- STAGGER, 2, cycles between consecutive domain releases (0 = all together)
- MAX_CYCLES, 100, watchdog period in cycles without kick (>=2)
- CNT_W, 32, width of cycle_cnt
- AUTO_RESTART, 1, 1 = re-sequence after timeout; 0 = halt in TIMEOUT

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset
- kick  in  1  watchdog restart (honoured in RUN only)
- dom_rst  out  NUM_DOMAINS  per-domain active-high reset
- all_released  out  1  all domains out of reset, state RUN
- cycle_cnt  out  CNT_W  cycles spent in RUN since last (re)sequence
- timeout  out  1  sticky: watchdog has expired at least once since rst
- timeout_pulse  out  1  one-cycle strobe per expiry
- timeout_cnt  out  8  number of expiries, saturating at 255

## Operation
- rst low (asynchronous):
  - state=HOLD, all dom_rst=1, all_released=0, cycle_cnt=0.
  - timeout=0, timeout_pulse=0, timeout_cnt=0, internal counters 0.
- rst deassertion passes through a 2-flop synchroniser (async assert, sync release).
- Edge A0 = 2nd posedge after rst rises.
- FSM states: HOLD -> STAGGER -> RUN -> TIMEOUT.
- HOLD:
  - seq_cnt counts from A0.
  - dom_rst[0] drops after edge A0+RST_CYCLES; move to STAGGER.
  - If NUM_DOMAINS==1 or STAGGER==0, all domains drop on that edge and the FSM goes directly to RUN.
- STAGGER:
  - dom_rst[i] drops after edge A0+RST_CYCLES+i*STAGGER.
  - Once dropped, a domain stays low until a timeout or rst.
  - The edge that drops dom_rst[NUM_DOMAINS-1] enters RUN.
- RUN:
  - all_released=1.
  - cycle_cnt increments every edge and saturates at all-ones.
  - wd_cnt clears on RUN entry and on kick, otherwise increments.
  - When wd_cnt reaches MAX_CYCLES-1 with no kick that cycle, the next edge expires the watchdog.
- Expiry (single edge):
  - timeout_pulse=1 for one cycle; timeout=1 (sticky).
  - timeout_cnt+1 (saturating at 255).
  - All dom_rst reassert together; all_released=0.
- After expiry:
  - AUTO_RESTART=1: go to HOLD; seq_cnt and cycle_cnt clear; the release sequence repeats from that edge, with that edge acting as A0.
  - AUTO_RESTART=0: go to TIMEOUT. It is terminal until rst; cycle_cnt freezes; kick is ignored.
- Boundaries:
  - kick on the same cycle as would-be expiry: kick wins, no expiry.
  - kick outside RUN: ignored.
  - rst asserted mid-sequence or mid-RUN: immediate return to reset values, including the sticky timeout.

## Timing
- All outputs are registered; no combinational path from kick to any output.
- Reset release to first domain release: 2 + RST_CYCLES edges.
- Reset release to all_released: 2 + RST_CYCLES + (NUM_DOMAINS-1)*STAGGER edges.
- Watchdog: expiry occurs MAX_CYCLES edges after the last kick or RUN entry.
- timeout_pulse and the dom_rst reassertion are visible after the same edge.

## Structure
- Package run_ctrl_pkg:
  - state enum {HOLD, STAGGER, RUN, TIMEOUT}.
  - Derived localparam widths: SEQ_W = $clog2(RST_CYCLES+NUM_DOMAINS*STAGGER+1), WD_W = $clog2(MAX_CYCLES).
- Sub-module rst_sync: 2-flop async-assert/sync-deassert synchroniser, instantiated once.
- The remaining logic (FSM, seq_cnt, wd_cnt, output registers) lives in run_ctrl and is expected to be roughly 200 lines.

## Test plan
- Defaults; rst low 5 cycles then high -> dom_rst[0] falls after posedge 10, [1] after 12, [2] after 14, [3] after 16; all_released=1 after posedge 16.
- Defaults; kick every 50 cycles for 1000 cycles -> timeout stays 0, cycle_cnt=1000 at the end.
- Defaults; no kick -> timeout_pulse for exactly 1 cycle, 100 edges after RUN entry; all dom_rst=1, timeout_cnt=1, cycle_cnt=0; dom_rst[0] falls again 8 edges later.
- Defaults; kick asserted exactly on the wd_cnt=99 cycle -> no expiry; the next expiry comes 100 edges later.
- AUTO_RESTART=0, MAX_CYCLES=10 -> after expiry the FSM stays in TIMEOUT, dom_rst all 1, cycle_cnt frozen at 10, kick ignored for 50 cycles.
- rst pulsed low for 1 cycle mid-STAGGER (after dom_rst[1] fell) -> all outputs return to reset values asynchronously, timeout=0, and the full sequence restarts.
